dmem_responder: RTL

//   Data-memory responder for the CPU's load/store port: takes addr, we and write data from
//   the core and returns read data on the core's data_in.

---
 rtl/dmem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: posted write buffer draining into a single-port word array, with
// store-to-load forwarding. Optional address bounds checking under DMEM_BOUNDS_CHECK_EN.
module dmem_responder #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          we,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          re,
  output logic [DATA_W-1:0]             rdata,
  output logic                          rvalid,
  output logic                          wb_full,
  output logic [$clog2(WB_DEPTH):0]     wb_count,
  output logic                          err
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] mem       [DEPTH];
  logic [IW-1:0]     wb_idx_q  [WB_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WB_DEPTH];

  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q, err_q;

  logic [IW-1:0]     idx;
  logic              oob, full, push, drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data, ld_data;

  assign idx = addr[IW-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  // Widened so the comparison stays correct whatever ADDR_W is relative to DEPTH.
  logic [ADDR_W+31:0] addr_ext;
  assign addr_ext = {32'd0, addr};
  assign oob      = addr_ext >= (ADDR_W + 32)'(DEPTH);
`else
  logic unused_addr;
  assign unused_addr = ^addr;
  assign oob         = 1'b0;
`endif

  // Full is taken from the registered count only, so a same-cycle drain never frees a slot.
  assign full  = count_q == CW'(WB_DEPTH);
  assign push  = we && !full && !oob;
  assign drain = (count_q != '0) && !re;

  assign count_d = count_q + CW'(push) - CW'(drain);

  // Walk oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < int'(WB_DEPTH); k++) begin
      if (CW'(k) < count_q && wb_idx_q[head_q + PW'(k)] == idx) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[head_q + PW'(k)];
      end
    end
  end

  always_comb begin
    ld_data = mem[idx];
    if (oob) begin
      ld_data = '0;
    end else if (fwd_hit) begin
      ld_data = fwd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        tail_q <= tail_q + 1'b1;
      end
      if (drain) begin
        head_q <= head_q + 1'b1;
      end
      count_q  <= count_d;
      rvalid_q <= re;
      if (re) begin
        rdata_q <= ld_data;
      end
      err_q <= oob && (we || re);
    end
  end

  // Storage carries no reset: pending entries are discarded by clearing the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      wb_idx_q[tail_q]  <= idx;
      wb_data_q[tail_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && drain) begin
      mem[wb_idx_q[head_q]] <= wb_data_q[head_q];
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign wb_full  = full;
  assign wb_count = count_q;
  assign err      = err_q;

endmodule
